// File: rtl/display_scan_capture.sv
// Captures a multiplexed 8-digit display scan (active-low anodes plus digit value)
// into a stable frame of eight digit registers, flagging out-of-order or malformed scans.
module display_scan_capture #(
  parameter int SETTLE = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] an,
  input  logic [3:0] disp,
  input  logic       sample_en,
  input  logic       err_clr,
  output logic [3:0] dig0,
  output logic [3:0] dig1,
  output logic [3:0] dig2,
  output logic [3:0] dig3,
  output logic [3:0] dig4,
  output logic [3:0] dig5,
  output logic [3:0] dig6,
  output logic [3:0] dig7,
  output logic       frame_valid,
  output logic       seq_err,
  output logic       illegal_err,
  output logic       err_flag
);

  localparam logic [3:0] SETTLE_C = 4'(SETTLE);

  typedef enum logic [1:0] {SYNC, COLLECT, PUBLISH} state_e;

  logic [7:0] held_an_q, held_an_d;
  logic [3:0] held_disp_q, held_disp_d;
  logic [3:0] cnt_q, cnt_d;
  logic       cap_q, cap_d;
  logic       mismatch;

  // NOTE: every variable assigned in always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    held_an_d   = held_an_q;
    held_disp_d = held_disp_q;
    cnt_d       = cnt_q;
    cap_d       = 1'b0;
    mismatch    = ({an, disp} != {held_an_q, held_disp_q});
    if (sample_en) begin
      if (mismatch) begin
        held_an_d   = an;
        held_disp_d = disp;
        cnt_d       = 4'd1;
      end else if (cnt_q < SETTLE_C) begin
        cnt_d = cnt_q + 4'd1;
      end
      // A count already parked at SETTLE never re-captures the same sample.
      cap_d = (cnt_d == SETTLE_C) && (mismatch || (cnt_q != SETTLE_C));
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      held_an_q   <= 8'hFF;
      held_disp_q <= 4'd0;
      cnt_q       <= 4'd0;
      cap_q       <= 1'b0;
    end else begin
      held_an_q   <= held_an_d;
      held_disp_q <= held_disp_d;
      cnt_q       <= cnt_d;
      cap_q       <= cap_d;
    end
  end

  // The captured sample stays in the held registers for the cycle cap_q is high.
  logic [7:0] inv_an;
  logic [2:0] cap_idx;
  logic       cap_valid, cap_blank;

  always_comb begin
    inv_an  = ~held_an_q;
    cap_idx = 3'd0;
    for (int k = 0; k < 8; k++) begin
      if (inv_an[k]) cap_idx = 3'(k);
    end
    cap_blank = (held_an_q == 8'hFF);
    cap_valid = !cap_blank && ((inv_an & (inv_an - 8'd1)) == 8'd0);
  end

  state_e     state_q;
  logic [2:0] expect_q;
  logic [3:0] shadow_q [8];
  logic [3:0] dig_q    [8];
  logic       frame_valid_q, seq_err_q, illegal_err_q, err_flag_q;
  logic       ill_hit, seq_hit;

  assign ill_hit = cap_q && !cap_blank && !cap_valid;
  assign seq_hit = cap_q && cap_valid && (state_q == COLLECT) && (cap_idx != expect_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= SYNC;
      expect_q      <= 3'd0;
      frame_valid_q <= 1'b0;
      seq_err_q     <= 1'b0;
      illegal_err_q <= 1'b0;
      err_flag_q    <= 1'b0;
      // NOTE: the shadow frame is a small register file, not a RAM; it is reset so a
      // discarded partial frame can never leak stale digits after reset.
      for (int k = 0; k < 8; k++) begin
        shadow_q[k] <= 4'd0;
        dig_q[k]    <= 4'd0;
      end
    end else begin
      frame_valid_q <= 1'b0;
      seq_err_q     <= seq_hit;
      illegal_err_q <= ill_hit;
      if (ill_hit || seq_hit) err_flag_q <= 1'b1;
      else if (err_clr)       err_flag_q <= 1'b0;

      if (state_q == PUBLISH) begin
        for (int k = 0; k < 8; k++) dig_q[k] <= shadow_q[k];
        frame_valid_q <= 1'b1;
        state_q       <= SYNC;
      end

      // Later assignments win, so an illegal capture overrides everything above.
      if (ill_hit) begin
        state_q <= SYNC;
      end else if (cap_q && cap_valid) begin
        if (state_q == COLLECT && cap_idx == expect_q) begin
          shadow_q[cap_idx] <= held_disp_q;
          expect_q          <= expect_q + 3'd1;
          if (cap_idx == 3'd7) state_q <= PUBLISH;
        end else if (cap_idx == 3'd0) begin
          shadow_q[0] <= held_disp_q;
          expect_q    <= 3'd1;
          state_q     <= COLLECT;
        end else if (state_q == COLLECT) begin
          state_q <= SYNC;
        end
      end
    end
  end

  assign dig0        = dig_q[0];
  assign dig1        = dig_q[1];
  assign dig2        = dig_q[2];
  assign dig3        = dig_q[3];
  assign dig4        = dig_q[4];
  assign dig5        = dig_q[5];
  assign dig6        = dig_q[6];
  assign dig7        = dig_q[7];
  assign frame_valid = frame_valid_q;
  assign seq_err     = seq_err_q;
  assign illegal_err = illegal_err_q;
  assign err_flag    = err_flag_q;

endmodule

// File: tb/tb_display_scan_capture.sv
// Scoreboard bench: scan segments feed a frame-level reference model that queues the
// expected frame/error pulses; a monitor pops and compares whenever the DUT pulses.
module tb_display_scan_capture;

  localparam int SETTLE_A = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, err_clr, sample_en, b_en;
  logic [7:0] an, b_an;
  logic [3:0] disp, b_disp;
  wire [31:0] a_digs, b_digs;
  wire        a_fv, a_seq, a_ill, a_err;
  wire        b_fv, b_seq, b_ill, b_err;

  int checks = 0;
  int errors = 0;
  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  display_scan_capture #(.SETTLE(SETTLE_A)) u_dut (
    .clk(clk), .reset(reset), .an(an), .disp(disp), .sample_en(sample_en), .err_clr(err_clr),
    .dig0(a_digs[3:0]), .dig1(a_digs[7:4]), .dig2(a_digs[11:8]), .dig3(a_digs[15:12]),
    .dig4(a_digs[19:16]), .dig5(a_digs[23:20]), .dig6(a_digs[27:24]), .dig7(a_digs[31:28]),
    .frame_valid(a_fv), .seq_err(a_seq), .illegal_err(a_ill), .err_flag(a_err)
  );

  // Single-sample settle instance: the only setting where a digit-0 capture can land in PUBLISH.
  display_scan_capture #(.SETTLE(1)) u_dut_fast (
    .clk(clk), .reset(reset), .an(b_an), .disp(b_disp), .sample_en(b_en), .err_clr(1'b0),
    .dig0(b_digs[3:0]), .dig1(b_digs[7:4]), .dig2(b_digs[11:8]), .dig3(b_digs[15:12]),
    .dig4(b_digs[19:16]), .dig5(b_digs[23:20]), .dig6(b_digs[27:24]), .dig7(b_digs[31:28]),
    .frame_valid(b_fv), .seq_err(b_seq), .illegal_err(b_ill), .err_flag(b_err)
  );

  typedef enum int {EV_FRAME, EV_SEQ, EV_ILL} ev_kind_e;
  typedef struct {
    ev_kind_e    kind;
    int          edge_n;
    logic [31:0] digs;
  } ev_t;

  ev_t         exp_q[$];
  int          m_next;          // -1: hunting for digit 0, else the digit index wanted next
  logic [3:0]  m_shadow [8];
  logic [11:0] prev_sample;
  bit          gaps_on;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  function automatic void push_ev(input ev_kind_e k, input int e, input logic [31:0] d);
    ev_t ev;
    ev.kind   = k;
    ev.edge_n = e;
    ev.digs   = d;
    exp_q.push_back(ev);
  endfunction

  // Frame-level rules applied to one settled capture whose sample lands on edge t.
  task automatic model_capture(input logic [7:0] a, input logic [3:0] d, input int t);
    logic [7:0]  inv;
    logic [31:0] frame;
    int          idx;
    if (a == 8'hFF) return;
    inv = ~a;
    if ($countones(inv) != 1) begin
      push_ev(EV_ILL, t + 1, 32'd0);
      m_next = -1;
      return;
    end
    idx = 0;
    for (int k = 0; k < 8; k++) if (inv[k]) idx = k;
    if (m_next >= 1 && idx == m_next) begin
      m_shadow[idx] = d;
      if (idx == 7) begin
        for (int k = 0; k < 8; k++) frame[4*k +: 4] = m_shadow[k];
        push_ev(EV_FRAME, t + 2, frame);
        m_next = -1;
      end else begin
        m_next++;
      end
    end else begin
      if (m_next >= 1) push_ev(EV_SEQ, t + 1, 32'd0);
      if (idx == 0) begin
        m_shadow[0] = d;
        m_next      = 1;
      end else begin
        m_next = -1;
      end
    end
  endtask

  // One display segment: a value held for len cycles; the first sample is always enabled.
  task automatic seg(input logic [7:0] a, input logic [3:0] d, input int len, input int clr_at = -1);
    int n_en = 0;
    logic en;
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      en        = (i == 0) || !gaps_on || ($urandom_range(0, 3) != 0);
      an        = a;
      disp      = d;
      sample_en = en;
      err_clr   = (i == clr_at);
      if (en) begin
        n_en++;
        if (n_en == SETTLE_A) model_capture(a, d, edge_n + 1);
      end
    end
    prev_sample = {a, d};
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      sample_en = 1'b0;
      err_clr   = 1'b0;
    end
  endtask

  task automatic scan_range(input logic [31:0] digs, input int lo, input int hi);
    logic [7:0] a;
    for (int k = lo; k <= hi; k++) begin
      a    = 8'hFF;
      a[k] = 1'b0;
      seg(a, digs[4*k +: 4], 3);
    end
  endtask

  task automatic pulse_err_clr();
    @(negedge clk);
    sample_en = 1'b0;
    err_clr   = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset     = 1'b1;
    sample_en = 1'b0;
    err_clr   = 1'b0;
    b_en      = 1'b0;
    repeat (2) @(negedge clk);
    reset       = 1'b0;
    m_next      = -1;
    prev_sample = {8'hFF, 4'h0};
  endtask

  // Scoreboard monitor for the SETTLE=2 instance.
  task automatic match(input ev_kind_e k, input string name);
    ev_t ev;
    if (exp_q.size() == 0) begin
      check({"spurious_", name}, exp_q.size(), 1);
      return;
    end
    ev = exp_q.pop_front();
    check({name, "_kind"}, k, ev.kind);
    check({name, "_edge"}, edge_n, ev.edge_n);
    if (k == EV_FRAME) check("frame_digits", a_digs, ev.digs);
  endtask

  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].edge_n < edge_n) begin
      check("missed_event_edge", edge_n, exp_q[0].edge_n);
      void'(exp_q.pop_front());
    end
    if (a_fv === 1'b1)  match(EV_FRAME, "frame_valid");
    if (a_seq === 1'b1) match(EV_SEQ, "seq_err");
    if (a_ill === 1'b1) match(EV_ILL, "illegal_err");
  end

  // Back-to-back scans on the fast instance: scan s, digit k shows (8s+k+1) mod 16.
  function automatic logic [31:0] b_frame_exp(input int s);
    logic [31:0] f;
    for (int k = 0; k < 8; k++) f[4*k +: 4] = 4'((s * 8 + k + 1) % 16);
    return f;
  endfunction

  int b_frames = 0;
  int b_last_edge = 0;
  always @(negedge clk) begin
    if (b_fv === 1'b1) begin
      check("fast_frame_digits", b_digs, b_frame_exp(b_frames));
      if (b_frames > 0) check("fast_frame_spacing", edge_n - b_last_edge, 8);
      b_last_edge = edge_n;
      b_frames++;
    end
    if (b_seq === 1'b1 || b_ill === 1'b1) check("fast_error_pulse", {b_seq, b_ill}, 2'b00);
  end

  initial begin
    logic [7:0] a;
    logic [3:0] d;
    int         p, r, len, i, j;

    reset = 1'b1; an = 8'hFF; disp = 4'h0; sample_en = 1'b0; err_clr = 1'b0;
    b_an = 8'hFF; b_disp = 4'h0; b_en = 1'b0; gaps_on = 1'b0;
    m_next = -1; prev_sample = {8'hFF, 4'h0};
    for (int k = 0; k < 8; k++) m_shadow[k] = 4'h0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    check("reset_digits", a_digs, 32'h0);
    check("reset_frame_valid", a_fv, 1'b0);
    check("reset_seq_err", a_seq, 1'b0);
    check("reset_illegal_err", a_ill, 1'b0);
    check("reset_err_flag", a_err, 1'b0);

    // Clean scan, digit k = k+1.
    scan_range(32'h87654321, 0, 7);
    idle(4);
    check("clean_digits", a_digs, 32'h87654321);
    check("clean_err_flag", a_err, 1'b0);

    // One-cycle glitch on an=FB between digits 2 and 3 must not capture.
    scan_range(32'h12345678, 0, 2);
    seg(8'hFB, 4'hA, 1);
    scan_range(32'h12345678, 3, 7);
    idle(4);
    check("glitch_digits", a_digs, 32'h12345678);

    // Out of order: digits 0,1 then 3.
    scan_range(32'h9ABCDEF0, 0, 1);
    seg(8'hF7, 4'h5, 3);
    idle(4);
    check("seq_err_flag", a_err, 1'b1);
    check("seq_digits_held", a_digs, 32'h12345678);
    scan_range(32'h0F1E2D3C, 0, 7);
    idle(4);
    check("after_seq_digits", a_digs, 32'h0F1E2D3C);
    pulse_err_clr();
    check("err_clr_clears", a_err, 1'b0);

    // Illegal anode pattern mid-frame.
    scan_range(32'h55555555, 0, 2);
    seg(8'hFC, 4'h5, 3);
    idle(4);
    check("illegal_digits_held", a_digs, 32'h0F1E2D3C);
    check("illegal_err_flag", a_err, 1'b1);
    pulse_err_clr();
    check("illegal_err_clr", a_err, 1'b0);

    // Blanks interleaved with every digit.
    for (int k = 0; k < 8; k++) begin
      seg(8'hFF, 4'(k), 3);
      scan_range(32'hA1B2C3D4, k, k);
    end
    idle(4);
    check("blank_digits", a_digs, 32'hA1B2C3D4);
    check("blank_err_flag", a_err, 1'b0);

    // err_clr on the same edge as a new seq_err: the error wins.
    scan_range(32'h11111111, 0, 1);
    seg(8'hEF, 4'h3, 3, 2);
    idle(4);
    check("clr_vs_error_flag", a_err, 1'b1);
    pulse_err_clr();

    // Reset after digit 4: partial frame discarded, outputs cleared.
    scan_range(32'h76543210, 0, 4);
    do_reset();
    check("midreset_digits", a_digs, 32'h0);
    check("midreset_err_flag", a_err, 1'b0);
    check("midreset_frame_valid", a_fv, 1'b0);
    scan_range(32'h2468ACE1, 0, 7);
    idle(4);
    check("postreset_digits", a_digs, 32'h2468ACE1);

    // Continuous one-cycle-per-digit scans on the fast instance.
    for (int s = 0; s < 3; s++) begin
      for (int k = 0; k < 8; k++) begin
        @(negedge clk);
        a = 8'hFF;
        a[k] = 1'b0;
        b_an   = a;
        b_disp = 4'((s * 8 + k + 1) % 16);
        b_en   = 1'b1;
      end
    end
    @(negedge clk);
    b_en = 1'b0;
    repeat (4) @(negedge clk);
    check("fast_frame_count", b_frames, 3);

    // Randomised scans with blanks, skips, illegal patterns, glitches and enable gaps.
    gaps_on = 1'b1;
    p = 0;
    repeat (300) begin
      r   = $urandom_range(0, 15);
      a   = 8'hFF;
      d   = 4'($urandom);
      len = $urandom_range(2, 4);
      case (r)
        0: a = 8'hFF;
        1: begin
          i = $urandom_range(0, 7);
          j = (i + 1 + $urandom_range(0, 6)) % 8;
          a[i] = 1'b0;
          a[j] = 1'b0;
        end
        2: a[$urandom_range(0, 7)] = 1'b0;
        3: begin
          a[$urandom_range(0, 7)] = 1'b0;
          len = 1;
        end
        default: begin
          a[p] = 1'b0;
          p = (p + 1) % 8;
        end
      endcase
      if ({a, d} == prev_sample) d = d + 4'd1;
      seg(a, d, len);
    end
    idle(10);
    check("pending_events", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
